// File: rtl/clock_pkg.sv
// Shared types, field encodings and time limits for the clock time-setting controller.
package clock_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 7;

    localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
    localparam logic [MIN_W-1:0]  MAX_MIN  = 7'd59;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_HOUR = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_COMMIT   = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FIELD_NONE = 2'd0,
        FIELD_HOUR = 2'd1,
        FIELD_MIN  = 2'd2
    } field_e;

    // >= also folds any out-of-range captured value back to zero
    function automatic logic [HOUR_W-1:0] hour_inc(input logic [HOUR_W-1:0] h);
        return (h >= MAX_HOUR) ? '0 : h + HOUR_W'(1);
    endfunction

    function automatic logic [MIN_W-1:0] min_inc(input logic [MIN_W-1:0] m);
        return (m >= MAX_MIN) ? '0 : m + MIN_W'(1);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus stability counter for one raw push-button.
// The debounced level and its edge pulses all change on the same clock edge.
module button_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             rise_q, fall_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts consecutive cycles the synchronized input disagrees with the accepted level
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= level_d & ~level_q;
            fall_q  <= ~level_d & level_q;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: buttons drive an hour/minute edit sequence, freeze the
// clock while editing, blink the edited field and issue a one-cycle load on commit.
//
//   state       | meaning
//   ST_RUN      | clock counting, waiting for a mode press
//   ST_SET_HOUR | clock frozen, inc edits the hour
//   ST_SET_MIN  | clock frozen, inc edits the minute
//   ST_COMMIT   | single cycle with load=1, then back to run
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int DEB_CYCLES    = 16,
    parameter int REPEAT_DLY    = 4,
    parameter int TIMEOUT_TICKS = 40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic              tick,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_minute,
    output logic              run_en,
    output logic              load,
    output logic [HOUR_W-1:0] load_hour,
    output logic [MIN_W-1:0]  load_minute,
    output logic [1:0]        edit_field,
    output logic              blink
);

    localparam int REP_W  = $clog2(REPEAT_DLY + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [REP_W-1:0]  REP_FULL  = REP_W'(REPEAT_DLY);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_TICKS - 1);

    logic mode_level, mode_rise, mode_fall;
    logic inc_level, inc_rise, inc_fall;
    logic unused_mode_bits;

    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk(clk), .reset(reset), .btn_i(btn_mode),
        .level_o(mode_level), .rise_o(mode_rise), .fall_o(mode_fall)
    );

    button_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
        .clk(clk), .reset(reset), .btn_i(btn_inc),
        .level_o(inc_level), .rise_o(inc_rise), .fall_o(inc_fall)
    );

    assign unused_mode_bits = mode_level ^ mode_fall;

    state_e              state_q;
    field_e              field_q;
    logic                run_en_q, load_q, blink_q;
    logic [HOUR_W-1:0]   hour_q;
    logic [MIN_W-1:0]    min_q;
    logic [REP_W-1:0]    rep_q, rep_d;
    logic [IDLE_W-1:0]   idle_q, idle_d;
    logic                in_set, rep_fire, do_inc, timeout;

    // Timeout is evaluated independently of presses so it beats a coincident mode press
    always_comb begin
        in_set   = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN);
        rep_fire = in_set && inc_level && tick && (rep_q == REP_FULL);
        do_inc   = (inc_rise || rep_fire) && !mode_rise;
        timeout  = in_set && tick && (idle_q == IDLE_LAST);

        rep_d = rep_q;
        if (!in_set || inc_fall) begin
            rep_d = '0;
        end else if (inc_level && tick && (rep_q != REP_FULL)) begin
            rep_d = rep_q + REP_W'(1);
        end

        idle_d = idle_q;
        if (!in_set || mode_rise || inc_rise) begin
            idle_d = '0;
        end else if (tick) begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_q  <= '0;
            idle_q <= '0;
        end else begin
            rep_q  <= rep_d;
            idle_q <= idle_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_RUN;
            field_q  <= FIELD_NONE;
            run_en_q <= 1'b1;
            load_q   <= 1'b0;
            blink_q  <= 1'b0;
            hour_q   <= '0;
            min_q    <= '0;
        end else begin
            load_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (mode_rise) begin
                        state_q  <= ST_SET_HOUR;
                        field_q  <= FIELD_HOUR;
                        run_en_q <= 1'b0;
                        blink_q  <= 1'b0;
                        hour_q   <= cur_hour;
                        min_q    <= cur_minute;
                    end
                end
                ST_SET_HOUR, ST_SET_MIN: begin
                    if (timeout) begin
                        state_q  <= ST_RUN;
                        field_q  <= FIELD_NONE;
                        run_en_q <= 1'b1;
                        blink_q  <= 1'b0;
                    end else if (mode_rise) begin
                        blink_q <= 1'b0;
                        if (state_q == ST_SET_HOUR) begin
                            state_q <= ST_SET_MIN;
                            field_q <= FIELD_MIN;
                        end else begin
                            state_q <= ST_COMMIT;
                            field_q <= FIELD_NONE;
                            load_q  <= 1'b1;
                        end
                    end else begin
                        if (tick) blink_q <= ~blink_q;
                        if (do_inc) begin
                            if (state_q == ST_SET_HOUR) hour_q <= hour_inc(hour_q);
                            else                        min_q  <= min_inc(min_q);
                        end
                    end
                end
                default: begin
                    state_q  <= ST_RUN;
                    field_q  <= FIELD_NONE;
                    run_en_q <= 1'b1;
                    blink_q  <= 1'b0;
                end
            endcase
        end
    end

    assign run_en      = run_en_q;
    assign load        = load_q;
    assign load_hour   = hour_q;
    assign load_minute = min_q;
    assign edit_field  = field_q;
    assign blink       = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: button sequences, wraps, auto-repeat, glitch,
// timeout and mid-edit reset, each checked against hand-computed values.
module tb_clock_set_ctrl;

    localparam int DEB = 16;
    localparam int RPT = 4;
    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_inc = 1'b0;
    logic       tick = 1'b0;
    logic [4:0] cur_hour = '0;
    logic [6:0] cur_minute = '0;
    logic       run_en, load, blink;
    logic [4:0] load_hour;
    logic [6:0] load_minute;
    logic [1:0] edit_field;

    int n_chk = 0;
    int n_pass = 0;
    int load_cnt = 0;
    int load_ref;

    clock_set_ctrl #(.DEB_CYCLES(DEB), .REPEAT_DLY(RPT), .TIMEOUT_TICKS(TMO)) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .tick(tick),
        .cur_hour(cur_hour), .cur_minute(cur_minute), .run_en(run_en), .load(load),
        .load_hour(load_hour), .load_minute(load_minute), .edit_field(edit_field), .blink(blink)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (load === 1'b1) load_cnt++;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_mode();
        btn_mode = 1'b1;
        cycles(DEB + 3);
        btn_mode = 1'b0;
        cycles(DEB + 4);
    endtask

    task automatic press_inc();
        btn_inc = 1'b1;
        cycles(DEB + 3);
        btn_inc = 1'b0;
        cycles(DEB + 4);
    endtask

    task automatic do_ticks(input int n);
        repeat (n) begin
            tick = 1'b1;
            cycles(1);
            tick = 1'b0;
            cycles(1);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cycles(3);
        n_chk++; if (run_en !== 1'b1) $display("FAIL reset_run_en: got %b want 1", run_en); else n_pass++;
        n_chk++; if (load !== 1'b0) $display("FAIL reset_load: got %b want 0", load); else n_pass++;
        n_chk++; if (load_hour !== 5'd0 || load_minute !== 7'd0)
            $display("FAIL reset_values: got %0d:%0d want 0:0", load_hour, load_minute); else n_pass++;
        n_chk++; if (edit_field !== 2'd0 || blink !== 1'b0)
            $display("FAIL reset_field_blink: got field %0d blink %b want 0 0", edit_field, blink); else n_pass++;
        reset = 1'b1;
        cycles(2);
    endtask

    task automatic test_enter_set();
        cur_hour = 5'd13; cur_minute = 7'd45;
        btn_mode = 1'b1;
        cycles(DEB + 2);
        n_chk++; if (edit_field !== 2'd0 || run_en !== 1'b1)
            $display("FAIL enter_early: got field %0d run_en %b want 0 1", edit_field, run_en); else n_pass++;
        cycles(1);
        n_chk++; if (edit_field !== 2'd1 || run_en !== 1'b0)
            $display("FAIL enter_state: got field %0d run_en %b want 1 0", edit_field, run_en); else n_pass++;
        n_chk++; if (load_hour !== 5'd13 || load_minute !== 7'd45)
            $display("FAIL enter_capture: got %0d:%0d want 13:45", load_hour, load_minute); else n_pass++;
        n_chk++; if (blink !== 1'b0) $display("FAIL enter_blink: got %b want 0", blink); else n_pass++;
        btn_mode = 1'b0;
        cycles(DEB + 4);
    endtask

    task automatic test_wrap_commit();
        repeat (10) press_inc();
        n_chk++; if (load_hour !== 5'd23) $display("FAIL hour_to_23: got %0d want 23", load_hour); else n_pass++;
        press_inc();
        n_chk++; if (load_hour !== 5'd0) $display("FAIL hour_wrap: got %0d want 0", load_hour); else n_pass++;
        press_mode();
        n_chk++; if (edit_field !== 2'd2 || load_minute !== 7'd45)
            $display("FAIL enter_min: got field %0d min %0d want 2 45", edit_field, load_minute); else n_pass++;
        repeat (14) press_inc();
        n_chk++; if (load_minute !== 7'd59) $display("FAIL min_to_59: got %0d want 59", load_minute); else n_pass++;
        press_inc();
        n_chk++; if (load_minute !== 7'd0) $display("FAIL min_wrap: got %0d want 0", load_minute); else n_pass++;
        load_ref = load_cnt;
        btn_mode = 1'b1;
        cycles(DEB + 2);
        n_chk++; if (load !== 1'b0) $display("FAIL commit_early: got load %b want 0", load); else n_pass++;
        cycles(1);
        n_chk++; if (load !== 1'b1 || run_en !== 1'b0)
            $display("FAIL commit_pulse: got load %b run_en %b want 1 0", load, run_en); else n_pass++;
        n_chk++; if (load_hour !== 5'd0 || load_minute !== 7'd0)
            $display("FAIL commit_value: got %0d:%0d want 0:0", load_hour, load_minute); else n_pass++;
        cycles(1);
        n_chk++; if (load !== 1'b0 || run_en !== 1'b1 || edit_field !== 2'd0)
            $display("FAIL after_commit: got load %b run_en %b field %0d want 0 1 0", load, run_en, edit_field); else n_pass++;
        btn_mode = 1'b0;
        cycles(DEB + 4);
        n_chk++; if (load_cnt !== load_ref + 1)
            $display("FAIL commit_count: got %0d loads want 1", load_cnt - load_ref); else n_pass++;
    endtask

    task automatic test_repeat();
        cur_hour = 5'd5; cur_minute = 7'd10;
        press_mode();
        press_mode();
        n_chk++; if (edit_field !== 2'd2 || load_minute !== 7'd10)
            $display("FAIL rpt_start: got field %0d min %0d want 2 10", edit_field, load_minute); else n_pass++;
        btn_inc = 1'b1;
        cycles(DEB + 3);
        n_chk++; if (load_minute !== 7'd11) $display("FAIL rpt_press: got %0d want 11", load_minute); else n_pass++;
        do_ticks(RPT);
        n_chk++; if (load_minute !== 7'd11) $display("FAIL rpt_delay: got %0d want 11", load_minute); else n_pass++;
        do_ticks(1);
        n_chk++; if (load_minute !== 7'd12 || blink !== 1'b1)
            $display("FAIL rpt_first: got min %0d blink %b want 12 1", load_minute, blink); else n_pass++;
        do_ticks(5);
        n_chk++; if (load_minute !== 7'd17 || blink !== 1'b0)
            $display("FAIL rpt_total: got min %0d blink %b want 17 0", load_minute, blink); else n_pass++;
        btn_inc = 1'b0;
        cycles(DEB + 4);
        do_ticks(2);
        n_chk++; if (load_minute !== 7'd17) $display("FAIL rpt_release: got %0d want 17", load_minute); else n_pass++;
        load_ref = load_cnt;
        press_mode();
        n_chk++; if (load_cnt !== load_ref + 1 || run_en !== 1'b1)
            $display("FAIL rpt_commit: got %0d loads run_en %b want 1 1", load_cnt - load_ref, run_en); else n_pass++;
    endtask

    task automatic test_glitch_simul();
        btn_mode = 1'b1;
        cycles(5);
        btn_mode = 1'b0;
        cycles(DEB + 10);
        n_chk++; if (edit_field !== 2'd0 || run_en !== 1'b1)
            $display("FAIL glitch: got field %0d run_en %b want 0 1", edit_field, run_en); else n_pass++;
        cur_hour = 5'd7; cur_minute = 7'd20;
        press_mode();
        btn_mode = 1'b1; btn_inc = 1'b1;
        cycles(DEB + 3);
        n_chk++; if (edit_field !== 2'd2 || load_hour !== 5'd7 || load_minute !== 7'd20)
            $display("FAIL simul_press: got field %0d %0d:%0d want 2 7:20", edit_field, load_hour, load_minute); else n_pass++;
        btn_mode = 1'b0; btn_inc = 1'b0;
        cycles(DEB + 4);
    endtask

    task automatic test_timeout();
        load_ref = load_cnt;
        do_ticks(TMO - 1);
        n_chk++; if (edit_field !== 2'd2) $display("FAIL tmo_min_early: got field %0d want 2", edit_field); else n_pass++;
        do_ticks(1);
        n_chk++; if (edit_field !== 2'd0 || run_en !== 1'b1)
            $display("FAIL tmo_min: got field %0d run_en %b want 0 1", edit_field, run_en); else n_pass++;
        press_mode();
        do_ticks(TMO - 1);
        n_chk++; if (edit_field !== 2'd1 || blink !== 1'b1)
            $display("FAIL tmo_hour_early: got field %0d blink %b want 1 1", edit_field, blink); else n_pass++;
        do_ticks(1);
        n_chk++; if (edit_field !== 2'd0 || run_en !== 1'b1 || blink !== 1'b0)
            $display("FAIL tmo_hour: got field %0d run_en %b blink %b want 0 1 0", edit_field, run_en, blink); else n_pass++;
        n_chk++; if (load_cnt !== load_ref) $display("FAIL tmo_load: got %0d loads want 0", load_cnt - load_ref); else n_pass++;
    endtask

    task automatic test_reset_mid_edit();
        cur_hour = 5'd9; cur_minute = 7'd30;
        press_mode();
        press_mode();
        press_inc();
        n_chk++; if (edit_field !== 2'd2 || load_minute !== 7'd31)
            $display("FAIL pre_reset: got field %0d min %0d want 2 31", edit_field, load_minute); else n_pass++;
        load_ref = load_cnt;
        reset = 1'b0;
        #1;
        n_chk++; if (run_en !== 1'b1 || load !== 1'b0 || edit_field !== 2'd0 || blink !== 1'b0)
            $display("FAIL mid_reset_ctrl: got run_en %b load %b field %0d blink %b", run_en, load, edit_field, blink); else n_pass++;
        n_chk++; if (load_hour !== 5'd0 || load_minute !== 7'd0)
            $display("FAIL mid_reset_values: got %0d:%0d want 0:0", load_hour, load_minute); else n_pass++;
        cycles(3);
        reset = 1'b1;
        cycles(50);
        n_chk++; if (load_cnt !== load_ref || run_en !== 1'b1 || edit_field !== 2'd0)
            $display("FAIL post_reset: got %0d loads run_en %b field %0d", load_cnt - load_ref, run_en, edit_field); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_enter_set();
        test_wrap_commit();
        test_repeat();
        test_glitch_simul();
        test_timeout();
        test_reset_mid_edit();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Time-setting controller for the digital clock. Turns the two board push-buttons into an edit sequence (hour, then minute). While editing it freezes the clock counter and blinks the field being edited. On commit it issues a one-cycle load of the new hour and minute into `fsmClock`, with seconds cleared. It sits between the board button inputs and `fsmClock`, and drives the display blanking.

## Interface
Parameters:
- `DEB_CYCLES`, default 16: consecutive stable cycles required to accept a button level.
- `REPEAT_DLY`, default 4: `tick` pulses that `btn_inc` must be held before auto-repeat starts.
- `TIMEOUT_TICKS`, default 40: idle `tick` pulses in a set state before the edit is aborted.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: asynchronous, active-low reset.
- `btn_mode` in 1: raw, asynchronous mode button (high = pressed).
- `btn_inc` in 1: raw, asynchronous increment button (high = pressed).
- `tick` in 1: one-cycle pulse at 4 Hz, used for blink, auto-repeat and timeout.
- `cur_hour` in 5: live hour from `fsmClock`.
- `cur_minute` in 7: live minute from `fsmClock`.
- `run_en` out 1: 1 lets `fsmClock` count; 0 freezes it.
- `load` out 1: one-cycle pulse that loads `load_hour` and `load_minute` and zeroes seconds.
- `load_hour` out 5: edit hour value, 0..23.
- `load_minute` out 7: edit minute value, 0..59.
- `edit_field` out 2: 0 = none, 1 = hour, 2 = minute.
- `blink` out 1: 1 = blank the field named by `edit_field`.

## Operation
- Each button passes through a 2-FF synchronizer and then a `button_debounce` stage.
  - The debounced level updates once the synchronized input has held one value for `DEB_CYCLES` consecutive cycles.
  - A press event is the one-cycle rising edge of the debounced level.
- The FSM has four states: RUN, SET_HOUR, SET_MIN, COMMIT.
- RUN:
  - `run_en`=1, `edit_field`=0.
  - A mode press captures `cur_hour`/`cur_minute` into the edit registers and moves to SET_HOUR.
  - Inc presses are ignored.
- SET_HOUR:
  - `run_en`=0, `edit_field`=1.
  - An inc press adds 1 to the hour, wrapping 23→0.
  - A mode press moves to SET_MIN.
- SET_MIN:
  - `run_en`=0, `edit_field`=2.
  - An inc press adds 1 to the minute, wrapping 59→0.
  - A mode press moves to COMMIT.
- COMMIT:
  - Lasts exactly one cycle, with `load`=1 and `run_en`=0.
  - The next state is RUN.
- Auto-repeat (set states only):
  - Once `btn_inc` has been debounced-high for `REPEAT_DLY` ticks, each further `tick` performs one increment.
  - Releasing the button clears the repeat counter.
- Timeout:
  - The idle counter counts ticks in the set states and is cleared by any press event.
  - When it reaches `TIMEOUT_TICKS`, the FSM goes to RUN with no load and the edit values are discarded.
- Blink: `blink` toggles on every `tick` in the set states. It is forced to 0 in RUN and COMMIT, and when entering a set state.
- Simultaneous mode and inc press events in the same cycle: mode wins, the inc is dropped.
- Mode press in the same cycle as a timeout: timeout wins.
- `load_hour` and `load_minute` are driven from the edit registers at all times. They are meaningful only while `load`=1.

## Timing
- Reset values:
  - state RUN, `run_en`=1, `load`=0.
  - `load_hour`=0, `load_minute`=0.
  - `edit_field`=0, `blink`=0.
  - All counters 0, debounced levels 0.
- Reset asserted mid-edit returns to RUN immediately and never produces a `load` pulse.
- Press latency: if raw input goes high and stays high from cycle N, the press event occurs in cycle N+2+`DEB_CYCLES`. The state and edit registers update on the following edge.
- `run_en` falls on the same edge that enters SET_HOUR.
- `run_en` rises on the edge leaving COMMIT, one cycle after `load`. `fsmClock` therefore sees `load` with counting frozen.
- A glitch shorter than `DEB_CYCLES` cycles produces no event.
- A release event (falling edge) does nothing except reset the auto-repeat counter.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `clock_pkg`:
  - state enum (RUN, SET_HOUR, SET_MIN, COMMIT);
  - `edit_field` encodings;
  - `MAX_HOUR`=23, `MAX_MIN`=59;
  - `HOUR_W`=5, `MIN_W`=7.
- Sub-module `button_debounce`, instantiated twice (mode, inc):
  - contains the synchronizer, the stability counter sized `$clog2(DEB_CYCLES+1)`, and the rising and falling edge pulses.
- The top level holds the FSM, the edit registers, and the repeat, idle and blink logic.

## Test plan
- Reset, then a clean mode press with `cur_hour`=13, `cur_minute`=45 → `run_en`=0, `edit_field`=1, `load_hour`=13 at press cycle+1.
- In SET_HOUR at hour 23: one inc press → `load_hour`=0. Then mode, inc ×15 from minute 45 → `load_minute`=0. Then mode → exactly one `load` cycle with 0/0, and `run_en`=1 on the next cycle.
- `btn_inc` held 10 ticks in SET_MIN from minute 10 (`REPEAT_DLY`=4) → 1 press increment plus 6 repeat increments → `load_minute`=17.
- 5-cycle glitch on `btn_mode` with `DEB_CYCLES`=16 → no state change. A mode press and an inc press rising in the same cycle in SET_HOUR → state SET_MIN, hour unchanged.
- Enter SET_HOUR and apply no presses for 40 ticks → state RUN, `load` never asserted, `run_en`=1.
- Deassert `reset` low during SET_MIN → all outputs return to reset values immediately and no `load` occurs after release.
